// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared period counter, per-channel duty comparators, shadowed config.
// Define DEADTIME_EN to add complementary outputs with per-channel dead-time insertion.

module pwm_multi_ch_lane #(
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dt,
  output logic             out,
  output logic             out_n
);
  logic r;
  assign r = cnt < duty;

`ifdef DEADTIME_EN
  logic            r_q;
  logic [DT_W-1:0] dtc, dtc_nxt;

  // Any edge of r reloads the delay; the newly asserted side waits for it to drain.
  always_comb begin
    dtc_nxt = '0;
    if (r != r_q)         dtc_nxt = dt;
    else if (dtc != '0)   dtc_nxt = dtc - DT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0; dtc <= '0; out <= 1'b0; out_n <= 1'b0;
    end else if (!en) begin
      r_q <= 1'b0; dtc <= '0; out <= 1'b0; out_n <= 1'b0;
    end else begin
      r_q   <= r;
      dtc   <= dtc_nxt;
      out   <= r  & (dtc_nxt == '0);
      out_n <= ~r & (dtc_nxt == '0);
    end
  end
`else
  logic unused;
  assign unused = ^dt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= 1'b0; out_n <= 1'b0;
    end else begin
      out   <= en & r;
      out_n <= en & ~r;
    end
  end
`endif
endmodule

module pwm_multi_ch #(
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  parameter int DT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_wr,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CH*CNT_W-1:0] cfg_duty,
  input  logic [DT_W-1:0]     cfg_dt,
  output logic [CH-1:0]       pwm_out,
  output logic [CH-1:0]       pwm_out_n,
  output logic                cycle_start,
  output logic                cfg_pending
);
  typedef struct packed {
    logic [CNT_W-1:0]          period;
    logic [CH-1:0][CNT_W-1:0]  duty;
    logic [DT_W-1:0]           dt;
  } cfg_t;

  cfg_t             wr_cfg, pend, act;
  logic [CNT_W-1:0] cnt;
  logic             wrap, xfer;

  assign wr_cfg = {cfg_period, cfg_duty, cfg_dt};
  assign wrap   = en & (cnt == act.period);
  // Active config only changes when the counter restarts, so no period sees mixed settings.
  assign xfer   = cfg_pending & (wrap | ~en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      pend        <= '0;
      act         <= '0;
      cfg_pending <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      if (!en || wrap) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
      if (xfer)   act  <= pend;
      if (cfg_wr) pend <= wr_cfg;
      cfg_pending <= cfg_wr | (cfg_pending & ~xfer);
      cycle_start <= en & (cnt == '0);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_multi_ch_lane #(.CNT_W(CNT_W), .DT_W(DT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .cnt   (cnt),
      .duty  (act.duty[i]),
      .dt    (act.dt),
      .out   (pwm_out[i]),
      .out_n (pwm_out_n[i])
    );
  end
endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Parametrised multi-channel PWM generator; next generation of the single-output fixed-threshold counter/PWM block. One shared period counter drives CH independent duty comparators with double-buffered (shadow) configuration, so updates apply glitch-free at period boundaries. Sits between the register interface and the output pads or gate drivers. Optional complementary outputs with dead-time insertion.

## Interface
- CH, 4, number of PWM channels (1..16)
- CNT_W, 16, counter/period/duty width
- DT_W, 8, dead-time count width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- en  in  1  run enable
- cfg_wr  in  1  one-cycle strobe capturing cfg_* into pending registers
- cfg_period  in  CNT_W  period value P; period length = P+1 cycles
- cfg_duty  in  CH*CNT_W  duty D per channel; channel i at bits [i*CNT_W +: CNT_W]
- cfg_dt  in  DT_W  dead time in cycles (ignored without DEADTIME_EN)
- pwm_out  out  CH  primary outputs, registered
- pwm_out_n  out  CH  complementary outputs, registered
- cycle_start  out  1  one-cycle pulse on first output cycle of each period
- cfg_pending  out  1  pending config not yet applied

## Operation
- Reset (rst=0, async): counter 0, active/pending period/duty/dt 0, pwm_out 0, pwm_out_n 0, cycle_start 0, cfg_pending 0.
- Counter: while en=1, increments each cycle; when counter == active P, next value 0 (wrap). CNT_W-bit unsigned, no overflow beyond P.
- Raw compare per channel: r[i] = (counter < active D[i]). D=0: always low. D >= P+1: always high. Unsigned compare.
- Shadow: cfg_wr loads pending regs, sets cfg_pending. Repeated writes before transfer: last wins.
- Transfer pending->active on the cycle the counter wraps to 0 (or any cycle while en=0), only if cfg_pending; clears cfg_pending.
- cfg_wr coincident with transfer: transfer uses old pending contents; new values land in pending; cfg_pending stays 1.
- en=0: counter held at 0, pwm_out and pwm_out_n forced 0 next cycle (both-off safe state), dead-time counters cleared.
- en 0->1: period starts at counter 0; cycle_start asserts on the first output cycle.

## Timing
- One-cycle latency: outputs at cycle t reflect counter value at t-1.
- cycle_start aligned with output cycle derived from counter 0.
- New active config first affects the period whose cycle_start follows the transfer.
- en deassert: outputs low 1 cycle later; async rst: outputs low immediately.

## Configuration
- Macro DEADTIME_EN.
- Defined: per-channel DT_W down-counter. r rising: pwm_out_n falls next cycle, pwm_out rises after active dt cycles of r held high. r falling: pwm_out falls next cycle, pwm_out_n rises after dt cycles of r held low. Pulse shorter than dt: delayed output never asserts. dt=0: pure complement. dt is transferred with period/duty.
- Undefined: no dead-time logic; pwm_out_n = ~pwm_out while en=1, 0 while en=0; cfg_dt ignored.

## Test plan
- Async reset mid-high pulse: drop rst with pwm_out=1 -> all outputs and cfg_pending 0 without clock edge; counter restarts at 0 after release.
- P=9, D={3,0,10,15}, en=1 -> ch0 high 3 of every 10 cycles, ch1 always low, ch2/ch3 always high, cycle_start every 10 cycles.
- Mid-period cfg_wr D0=7 then D0=5 -> cfg_pending=1 until next wrap; following period ch0 high 5 cycles.
- cfg_wr exactly on wrap cycle with D0=2 while pending D0=6 -> next period uses 6, cfg_pending stays 1, period after uses 2.
- DEADTIME_EN, P=9, D=5, dt=2 -> pwm_out high output cycles 2-4, pwm_out_n high cycles 7-9, both low cycles 0-1 and 5-6; D=1 -> pwm_out never high.
- en drop mid-period then re-raise -> outputs 0 next cycle, pending config applied while idle, cycle_start on first cycle after re-enable.
